iir_mac_control: RTL and testbench

Sequencer and multiply-accumulate datapath for the second-order IIR (Direct Form II biquad) section. It drives the select lines of the coefficient/operand multiplexer (`controlS`, `controlC`, `controlZ`) and consumes its outputs `muxS`, `muxC` and `muxZ`. It also owns the delay-line registers `fk`, `fk1`, `fk2` and the output sample `yk`. One filter sample is computed per `start` strobe in six MAC cycles.

---
 rtl/iir_mac_control.sv | 176 +++++++++++++++++
 tb/tb_iir_mac_control.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_mac_control.sv
// Sequencer and MAC datapath for one Direct Form II biquad section.
// Each accepted start strobe runs six MAC cycles, updates the delay line and
// publishes a new output sample together with a one-cycle done pulse.
module iir_mac_control #(
  parameter int N = 24,
  parameter int F = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic signed [N-1:0] xk,
  input  logic signed [N-1:0] muxS,
  input  logic signed [N-1:0] muxC,
  input  logic signed [N-1:0] muxZ,
  output logic        [2:0]   controlS,
  output logic        [1:0]   controlC,
  output logic        [1:0]   controlZ,
  output logic signed [N-1:0] Uk,
  output logic signed [N-1:0] fk,
  output logic signed [N-1:0] fk1,
  output logic signed [N-1:0] fk2,
  output logic signed [N-1:0] yk,
  output logic                busy,
  output logic                done
);

  localparam int unsigned AW = N + 2;   // accumulator width, headroom for 4 terms
  localparam int unsigned PW = 2 * N;   // full product width

  localparam logic signed [N-1:0] SMAX = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] SMIN = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    M0   = 3'd1,
    M1   = 3'd2,
    M2   = 3'd3,
    M3   = 3'd4,
    M4   = 3'd5,
    M5   = 3'd6,
    FIN  = 3'd7
  } state_t;

  state_t state, state_d;

  logic [2:0] sel_s_d;
  logic [1:0] sel_c_d;
  logic [1:0] sel_z_d;
  logic       busy_d;
  logic       done_d;
  logic       load_uk;

  logic signed [PW-1:0] prod_full;
  logic signed [PW-1:0] prod_sh;
  logic signed [N-1:0]  prod_sat;
  logic signed [AW-1:0] p;
  logic signed [AW-1:0] z_ext;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_next;

  // Clamp an accumulator value into the N-bit signed range.
  function automatic logic signed [N-1:0] sat_acc(input logic signed [AW-1:0] v);
    logic [AW-N:0] top;
    top = v[AW-1:N-1];
    if ((&top) || !(|top)) begin
      sat_acc = v[N-1:0];
    end else if (v[AW-1]) begin
      sat_acc = SMIN;
    end else begin
      sat_acc = SMAX;
    end
  endfunction

  // Product: full signed multiply, floor shift by F, clamp to N bits, extend to AW.
  always_comb begin
    prod_full = PW'(muxS) * PW'(muxC);
    prod_sh   = prod_full >>> F;
    if ((&prod_sh[PW-1:N-1]) || !(|prod_sh[PW-1:N-1])) begin
      prod_sat = prod_sh[N-1:0];
    end else if (prod_sh[PW-1]) begin
      prod_sat = SMIN;
    end else begin
      prod_sat = SMAX;
    end
    p     = {{2{prod_sat[N-1]}}, prod_sat};
    z_ext = {{2{muxZ[N-1]}}, muxZ};
  end

  // Accumulator update for the current MAC step.
  always_comb begin
    acc_next = acc;
    unique case (state)
      M0:                 acc_next = p + z_ext;
      M1, M2, M4, M5:     acc_next = acc + p;
      M3:                 acc_next = p;
      default:            acc_next = acc;
    endcase
  end

  // Next state and Moore control decode of the upcoming state.
  always_comb begin
    state_d = state;
    sel_s_d = 3'd0;
    sel_c_d = 2'd0;
    sel_z_d = 2'd0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    load_uk = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = M0;
          load_uk = 1'b1;
        end
      end
      M0:      state_d = M1;
      M1:      state_d = M2;
      M2:      state_d = M3;
      M3:      state_d = M4;
      M4:      state_d = M5;
      M5:      state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      M0: begin sel_s_d = 3'd0; sel_c_d = 2'd0; sel_z_d = 2'd1; busy_d = 1'b1; end
      M1: begin sel_s_d = 3'd1; sel_c_d = 2'd1; sel_z_d = 2'd0; busy_d = 1'b1; end
      M2: begin sel_s_d = 3'd2; sel_c_d = 2'd2; sel_z_d = 2'd0; busy_d = 1'b1; end
      M3: begin sel_s_d = 3'd3; sel_c_d = 2'd3; sel_z_d = 2'd0; busy_d = 1'b1; end
      M4: begin sel_s_d = 3'd4; sel_c_d = 2'd1; sel_z_d = 2'd0; busy_d = 1'b1; end
      M5: begin sel_s_d = 3'd5; sel_c_d = 2'd2; sel_z_d = 2'd0; busy_d = 1'b1; end
      FIN: begin busy_d = 1'b1; done_d = 1'b1; end
      default: begin end
    endcase
  end

  // State, registered controls and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      controlS <= 3'd0;
      controlC <= 2'd0;
      controlZ <= 2'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Uk       <= '0;
      fk       <= '0;
      fk1      <= '0;
      fk2      <= '0;
      yk       <= '0;
      acc      <= '0;
    end else begin
      state    <= state_d;
      controlS <= sel_s_d;
      controlC <= sel_c_d;
      controlZ <= sel_z_d;
      busy     <= busy_d;
      done     <= done_d;
      if (load_uk) begin
        Uk <= xk;
      end
      acc <= acc_next;
      if (state == M2) begin
        fk <= sat_acc(acc_next);
      end
      if (state == M5) begin
        yk  <= sat_acc(acc_next);
        fk2 <= fk1;
        fk1 <= fk;
      end
    end
  end

endmodule

// File: tb/tb_iir_mac_control.sv
// Bench for iir_mac_control: models the operand mux, checks the control
// sequence, impulse response, saturation, busy/start and reset behaviour,
// and random samples against a sample-level reference of the biquad.
module tb_iir_mac_control;

  localparam int N = 24;
  localparam int F = 14;

  localparam longint A1 = 32112;
  localparam longint A2 = -15736;
  localparam longint B0 = 16384;
  localparam longint B1 = -32768;
  localparam longint B2 = 16384;
  localparam longint VMAX = 8388607;
  localparam longint VMIN = -8388608;

  logic                clk;
  logic                reset;
  logic                start;
  logic signed [N-1:0] xk;
  logic signed [N-1:0] muxS;
  logic signed [N-1:0] muxC;
  logic signed [N-1:0] muxZ;
  logic        [2:0]   controlS;
  logic        [1:0]   controlC;
  logic        [1:0]   controlZ;
  logic signed [N-1:0] Uk;
  logic signed [N-1:0] fk;
  logic signed [N-1:0] fk1;
  logic signed [N-1:0] fk2;
  logic signed [N-1:0] yk;
  logic                busy;
  logic                done;

  int n_chk = 0;
  int n_err = 0;

  longint m_fk, m_fk1, m_fk2, m_yk, m_uk;

  int exp_s [6] = '{0, 1, 2, 3, 4, 5};
  int exp_c [6] = '{0, 1, 2, 3, 1, 2};
  int exp_z [6] = '{1, 0, 0, 0, 0, 0};

  typedef struct {
    longint x;
    longint yk;
    longint fk1;
    longint fk2;
  } vec_t;

  vec_t vt [3];

  iir_mac_control #(.N(N), .F(F)) dut (
    .clk(clk), .reset(reset), .start(start), .xk(xk),
    .muxS(muxS), .muxC(muxC), .muxZ(muxZ),
    .controlS(controlS), .controlC(controlC), .controlZ(controlZ),
    .Uk(Uk), .fk(fk), .fk1(fk1), .fk2(fk2), .yk(yk),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Coefficient/operand multiplexer model.
  always_comb begin
    case (controlS)
      3'd1:    muxS = 24'(A1);
      3'd2:    muxS = 24'(A2);
      3'd3:    muxS = 24'(B0);
      3'd4:    muxS = 24'(B1);
      3'd5:    muxS = 24'(B2);
      default: muxS = '0;
    endcase
    case (controlC)
      2'd1:    muxC = fk1;
      2'd2:    muxC = fk2;
      2'd3:    muxC = fk;
      default: muxC = '0;
    endcase
    case (controlZ)
      2'd1:    muxZ = Uk;
      2'd2:    muxZ = yk;
      default: muxZ = '0;
    endcase
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > VMAX) return VMAX;
    if (v < VMIN) return VMIN;
    return v;
  endfunction

  function automatic longint mul(input longint c, input longint v);
    return sat((c * v) >>> F);
  endfunction

  task automatic model_reset();
    m_fk = 0; m_fk1 = 0; m_fk2 = 0; m_yk = 0; m_uk = 0;
  endtask

  // One biquad sample: w = x + a1*w1 + a2*w2; y = b0*w + b1*w1 + b2*w2.
  task automatic model_step(input longint x);
    longint w, y;
    m_uk = x;
    w    = x + mul(A1, m_fk1) + mul(A2, m_fk2);
    m_fk = sat(w);
    y    = mul(B0, m_fk) + mul(B1, m_fk1) + mul(B2, m_fk2);
    m_yk = sat(y);
    m_fk2 = m_fk1;
    m_fk1 = m_fk;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_Uk"}, Uk, 0);
    chk({tag, "_fk"}, fk, 0);
    chk({tag, "_fk1"}, fk1, 0);
    chk({tag, "_fk2"}, fk2, 0);
    chk({tag, "_yk"}, yk, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ctrl"}, {controlS, controlC, controlZ}, 0);
  endtask

  // Run one sample to completion and compare against the reference model.
  task automatic do_sample(input longint x, input bit chkctrl);
    int cyc;
    @(negedge clk);
    start = 1'b1;
    xk    = 24'(x);
    @(negedge clk);
    start = 1'b0;
    xk    = 24'($urandom);
    model_step(x);
    cyc = 1;
    while (!done && cyc < 20) begin
      if (chkctrl && cyc <= 6) begin
        chk($sformatf("ctrlS_m%0d", cyc - 1), controlS, exp_s[cyc-1]);
        chk($sformatf("ctrlC_m%0d", cyc - 1), controlC, exp_c[cyc-1]);
        chk($sformatf("ctrlZ_m%0d", cyc - 1), controlZ, exp_z[cyc-1]);
        chk($sformatf("busy_m%0d", cyc - 1), busy, 1);
      end
      @(negedge clk);
      cyc++;
    end
    chk("done_latency", cyc, 7);
    chk("Uk", Uk, m_uk);
    chk("fk", fk, m_fk);
    chk("yk", yk, m_yk);
    chk("fk1", fk1, m_fk1);
    chk("fk2", fk2, m_fk2);
  endtask

  initial begin
    int ndone;
    logic signed [N-1:0] r;
    longint x;

    vt[0] = '{x: 16384, yk: 16384, fk1: 16384, fk2: 0};
    vt[1] = '{x: 0,     yk: -656,  fk1: 32112, fk2: 16384};
    vt[2] = '{x: 0,     yk: -638,  fk1: 47202, fk2: 32112};

    reset = 1'b1;
    start = 1'b0;
    xk    = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_all_zero("rst_hold");
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_release");

    // Impulse response table.
    for (int i = 0; i < 3; i++) begin
      do_sample(vt[i].x, 1'b1);
      chk($sformatf("tbl%0d_yk", i), yk, vt[i].yk);
      chk($sformatf("tbl%0d_fk1", i), fk1, vt[i].fk1);
      chk($sformatf("tbl%0d_fk2", i), fk2, vt[i].fk2);
    end

    // Start while busy: second strobe in M2 must be ignored.
    @(negedge clk);
    start = 1'b1;
    xk    = 24'(100);
    @(negedge clk);
    start = 1'b0;
    model_step(100);
    @(negedge clk);
    @(negedge clk);
    chk("busy_in_m2", controlS, 2);
    start = 1'b1;
    xk    = 24'(5);
    @(negedge clk);
    start = 1'b0;
    chk("busy_Uk_kept", Uk, 100);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) begin
        ndone++;
        chk("busy_yk", yk, m_yk);
        chk("busy_fk1", fk1, m_fk1);
      end
      @(negedge clk);
    end
    chk("busy_done_count", ndone, 1);
    chk("busy_idle_after", busy, 0);

    // Reset during M4 aborts the sequence.
    @(negedge clk);
    start = 1'b1;
    xk    = 24'(777);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_in_m4", controlS, 4);
    #2 reset = 1'b1;
    #1 chk_all_zero("abort");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", ndone, 0);
    do_sample(16384, 1'b1);
    chk("fresh_yk", yk, 16384);
    chk("fresh_fk1", fk1, 16384);
    chk("fresh_fk2", fk2, 0);

    // Asynchronous reset mid-cycle with a non-zero delay line.
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_all_zero("async");
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Saturation: drive full-scale positive input repeatedly.
    do_sample(VMAX, 1'b0);
    chk("sat1_fk", fk, VMAX);
    chk("sat1_yk", yk, VMAX);
    for (int i = 0; i < 5; i++) do_sample(VMAX, 1'b0);
    for (int i = 0; i < 4; i++) do_sample(VMIN, 1'b0);

    // Random samples against the reference.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: x = longint'($urandom_range(0, 40000)) - 20000;
        1: begin r = 24'($urandom); x = r; end
        2: x = VMAX;
        default: x = VMIN;
      endcase
      do_sample(x, (i % 8) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
